// File: rtl/bnn_pkg.sv
// Shared constants and types for the tiny BNN parameter chain and its loader.
package bnn_pkg;

  localparam int unsigned INPUTS         = 8;
  localparam int unsigned THRESH_W       = 4;
  localparam int unsigned HIDDEN_UNITS   = 12;
  localparam int unsigned GLOBAL_OUTPUTS = 4;

  // One neuron holds a weight bit per input plus its threshold.
  localparam int unsigned NEURON_BITS    = INPUTS + THRESH_W;
  localparam int unsigned DEF_CHAIN_BITS = (HIDDEN_UNITS + GLOBAL_OUTPUTS) * NEURON_BITS;
  localparam int unsigned DEF_WORD_W     = 8;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_FETCH,
    LD_SHIFT,
    LD_FINISH
  } loader_state_e;

endpackage

// File: rtl/bnn_word_serializer.sv
// Holds one host word and emits it LSB first; tracks the bit position within the word.
module bnn_word_serializer
  import bnn_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic              last_c
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= data;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg >> 1;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign bit_out = shreg[0];
  // High while the final bit of the current word is on bit_out.
  assign last_c  = (idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/bnn_param_loader.sv
// Serialises host parameter words onto the BNN chain, CHAIN_BITS bits per pass.
// Optional chain read-back check enabled by defining BNN_LOADER_VERIFY_EN.
module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int unsigned CHAIN_BITS = DEF_CHAIN_BITS,
  parameter int unsigned WORD_W     = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              setup,
  output logic              param_bit,
  input  logic              param_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam int unsigned CNT_W = $clog2(CHAIN_BITS + 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             shift_c;
  logic             word_last_c;
  logic             in_ready_d, setup_d, busy_d, done_d;

  bnn_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept_c),
    .shift   (shift_c),
    .data    (in_data),
    .bit_out (param_bit),
    .last_c  (word_last_c)
  );

  // Next state, total bit count and next-cycle output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_FETCH;
          cnt_d   = '0;
        end
      end
      LD_FETCH: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = LD_SHIFT;
        end
      end
      LD_SHIFT: begin
        shift_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CHAIN_BITS - 1)) begin
          state_d = LD_FINISH;
        end else if (word_last_c) begin
          state_d = LD_FETCH;
        end
      end
      LD_FINISH: state_d = LD_IDLE;
      default:   state_d = LD_IDLE;
    endcase

    in_ready_d = (state_d == LD_FETCH);
    setup_d    = (state_d == LD_SHIFT);
    busy_d     = (state_d == LD_FETCH) || (state_d == LD_SHIFT);
    done_d     = (state_d == LD_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LD_IDLE;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      setup    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_ready <= in_ready_d;
      setup    <= setup_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef BNN_LOADER_VERIFY_EN
  logic verify_q, verify_d;
  logic verify_err_q, verify_err_d;

  // Tail must replay the bit sent CHAIN_BITS shifts earlier; any difference is sticky.
  always_comb begin
    verify_d     = verify_q;
    verify_err_d = verify_err_q;
    if ((state_q == LD_IDLE) && start) begin
      verify_d = verify;
      if (verify) begin
        verify_err_d = 1'b0;
      end
    end else if ((state_q == LD_SHIFT) && verify_q && (param_tail != param_bit)) begin
      verify_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      verify_q     <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      verify_q     <= verify_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign verify_err = verify_err_q;
`else
  logic unused_verify_inputs;
  assign unused_verify_inputs = verify ^ param_tail;
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench: a 16-bit chain loader with a model chain, plus a 12-bit chain loader.
`timescale 1ns/1ps
module tb_bnn_param_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, verify, in_valid, sel;
  logic [7:0] in_data;
  logic       start_a, start_b;
  logic       in_ready_a, setup_a, param_bit_a, busy_a, done_a, verr_a;
  logic       in_ready_b, setup_b, param_bit_b, busy_b, done_b, verr_b;
  logic       in_ready, setup, param_bit, busy, done, verr;
  logic [15:0] chain = '0;
  logic       param_tail;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  bnn_param_loader #(.CHAIN_BITS(16), .WORD_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .verify(verify),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .setup(setup_a), .param_bit(param_bit_a), .param_tail(param_tail),
    .busy(busy_a), .done(done_a), .verify_err(verr_a)
  );

  bnn_param_loader #(.CHAIN_BITS(12), .WORD_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .verify(verify),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .setup(setup_b), .param_bit(param_bit_b), .param_tail(1'b0),
    .busy(busy_b), .done(done_b), .verify_err(verr_b)
  );

  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign setup     = sel ? setup_b     : setup_a;
  assign param_bit = sel ? param_bit_b : param_bit_a;
  assign busy      = sel ? busy_b      : busy_a;
  assign done      = sel ? done_b      : done_a;
  assign verr      = sel ? verr_b      : verr_a;

  // Model of a 16-deep neuron chain: the first bit shifted ends at the tail.
  assign param_tail = chain[0];
  always @(posedge clk) if (setup_a) chain <= {param_bit_a, chain[15:1]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic bits[$];
  int   n_setup = 0, n_acc = 0, n_done = 0;
  always @(negedge clk) begin
    if (setup) begin
      bits.push_back(param_bit);
      n_setup++;
    end
    if (in_valid && in_ready) n_acc++;
    if (done) n_done++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // One two-word pass; optional host stall before word 1 and a start poke while busy.
  task automatic run_pass(input logic s, input logic v, input logic [7:0] w0,
                          input logic [7:0] w1, input int gap, input logic poke,
                          input logic [15:0] exp_bits, input int nbits, input string tag);
    int b0, s0, a0, d0, t0, len;
    logic [7:0]  w;
    logic [15:0] got;
    b0 = bits.size(); s0 = n_setup; a0 = n_acc; d0 = n_done;
    sel = s;
    @(negedge clk);
    start = 1'b1; verify = v; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? w0 : w1;
      wait_ready(tag);
      if (i == 1 && gap > 0) begin
        for (int g = 0; g < gap; g++) begin
          chk({tag, "_stall_setup"}, 32'(setup), 32'd0);
          @(negedge clk);
        end
      end
      in_data = w; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_first_setup"}, 32'(setup), 32'd1);
      chk({tag, "_first_bit"}, 32'(param_bit), 32'(w[0]));
      if (i == 0 && poke) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_done(tag);
    len = cyc - t0;
    chk({tag, "_len"}, 32'(len), 32'(2 + nbits + 1 + gap));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    got = '0;
    for (int i = 0; i < nbits; i++) if (b0 + i < bits.size()) got[i] = bits[b0 + i];
    chk({tag, "_bits"}, 32'(got), 32'(exp_bits));
    chk({tag, "_setup_cycles"}, 32'(n_setup - s0), 32'(nbits));
    chk({tag, "_words"}, 32'(n_acc - a0), 32'd2);
    chk({tag, "_done_count"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors expected end", n_vec);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; verify = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({in_ready_a, setup_a, param_bit_a, busy_a, done_a, verr_a}), 32'd0);
    chk("reset_b", 32'({in_ready_b, setup_b, param_bit_b, busy_b, done_b, verr_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'({in_ready_a, busy_a}), 32'd0);

    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 0, 1'b0, 16'h3CA5, 16, "full");
    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 5, 1'b0, 16'h3CA5, 16, "stall");
    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 0, 1'b1, 16'h3CA5, 16, "poke");

`ifdef BNN_LOADER_VERIFY_EN
    run_pass(1'b0, 1'b1, 8'hA5, 8'h3C, 0, 1'b0, 16'h3CA5, 16, "ver_ok");
    chk("verify_match", 32'(verr), 32'd0);
    run_pass(1'b0, 1'b1, 8'hA5, 8'h3D, 0, 1'b0, 16'h3DA5, 16, "ver_bad");
    chk("verify_mismatch", 32'(verr), 32'd1);
    repeat (3) @(negedge clk);
    chk("verify_sticky", 32'(verr), 32'd1);
    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 0, 1'b0, 16'h3CA5, 16, "plain_after");
    chk("verify_kept_by_plain", 32'(verr), 32'd1);
`else
    run_pass(1'b0, 1'b1, 8'hA5, 8'h3D, 0, 1'b0, 16'h3DA5, 16, "ver_off");
    chk("verify_tied_low", 32'(verr), 32'd0);
`endif

    // Reset after 5 shifted bits, then a clean reload.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; verify = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_fetch", 32'(in_ready_a), 32'd1);
    in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_shifting", 32'(setup_a), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({in_ready_a, setup_a, param_bit_a, busy_a, done_a, verr_a}), 32'd0);
    rst_n = 1'b1;
    run_pass(1'b0, 1'b0, 8'hA5, 8'h3C, 0, 1'b0, 16'h3CA5, 16, "reload");

    run_pass(1'b1, 1'b0, 8'hFF, 8'h0F, 0, 1'b0, 16'h0FFF, 12, "partial");
    chk("partial_a_idle", 32'(busy_a), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Upstream feeder for the tiny BNN parameter chain. Accepts parameter words from the host side over a valid/ready handshake and serialises them, one bit per clock, onto the neurons' `param_in` chain while driving `setup`. Counts exactly `CHAIN_BITS` shifted bits, then releases `setup` and pulses `done`. An optional verify pass checks the chain tail against a second identical stream.

## Interface

**Parameters**

- `CHAIN_BITS`, default 192: total parameter bits in the neuron chain (16 neurons × 12 bits).
- `WORD_W`, default 8: width of one host parameter word.

**Ports**

- `clk`  in  1: chain clock, same clock as the neurons.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begin a load pass; sampled only in IDLE.
- `verify`  in  1: sampled with `start`; selects a verify pass (see Configuration).
- `in_data`  in  `WORD_W`: parameter word, shifted out LSB first.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader accepts a word this cycle.
- `setup`  out  1: drives the chain `setup`; high only in cycles where `param_bit` is a real bit.
- `param_bit`  out  1: serial bit to the chain head `param_in`.
- `param_tail`  in  1: chain tail output; used only when verify is enabled.
- `busy`  out  1: a pass is in progress.
- `done`  out  1: one-cycle pulse after the last bit is shifted.
- `verify_err`  out  1: sticky mismatch flag for the last verify pass.

## Operation

**State machine** (registered, one-hot or encoded):

- **IDLE**
  - `busy`=0, `setup`=0, `in_ready`=0.
  - `start`=1 → FETCH. On that edge: clear the bit counter, latch `verify`, and clear `verify_err` if `verify`=1.
- **FETCH**
  - `in_ready`=1, `setup`=0.
  - `in_valid`&&`in_ready` → load the word into the shift register, set the in-word index to 0 → SHIFT.
- **SHIFT**
  - `setup`=1, `param_bit`=`shreg[0]`.
  - Each cycle: `shreg` shifts right, the total count increments, the in-word index increments.
  - If the total count reaches `CHAIN_BITS` → FINISH.
  - Else, if the in-word index reaches `WORD_W` → FETCH.
- **FINISH**
  - `setup`=0, `done`=1 for one cycle → IDLE.

**Counting and bit order**

- Bit counter width: `$clog2(CHAIN_BITS+1)`. It never wraps.
- Host supplies ceil(`CHAIN_BITS`/`WORD_W`) words. Unused high bits of the final word are discarded.
- Bits are shifted LSB first, words in arrival order. The first bit shifted ends at the chain tail.

**Boundary conditions**

- Host stall (FETCH with `in_valid`=0): `setup` stays low, so the chain holds. No garbage bits are shifted.
- `start` while `busy`: ignored.
- Words offered in IDLE/SHIFT/FINISH: not accepted (`in_ready`=0).
- `rst_n`=0 mid-pass: state returns to IDLE on that edge. Chain contents are partial and unspecified, and the host must reload.

## Timing

- Reset values: `in_ready`=0, `setup`=0, `param_bit`=0, `busy`=0, `done`=0, `verify_err`=0.
- All outputs are registered or decoded from registered state only; no input→output combinational path.
- Word accept edge → first bit on `param_bit` in the next cycle.
- A word's `WORD_W` bits appear on `WORD_W` consecutive cycles with `setup`=1.
- Minimum pass length with `in_valid` held high: 1 (IDLE→FETCH) + N×(1+`WORD_W`) cycles, roughly, where N is the word count. It is exactly `CHAIN_BITS` setup-high cycles plus one FETCH cycle per word.
- `done` is asserted in the cycle after the final setup-high cycle. `busy` drops in the same cycle `done` pulses.

## Configuration

`BNN_LOADER_VERIFY_EN`

- **Defined:**
  - In a pass started with `verify`=1, the host resends the identical stream.
  - In every SHIFT cycle, `param_tail` must equal `param_bit`, because the tail emits the bit sent `CHAIN_BITS` shifts earlier.
  - Any mismatch sets `verify_err`, which stays set until the next verify `start` or reset.
- **Undefined:**
  - `verify` input ignored, `param_tail` unused, `verify_err` tied 0.
  - A pass with `verify`=1 behaves as a normal load.

## Structure

- Shared package `bnn_pkg`:
  - loader state enum;
  - default `CHAIN_BITS` derived from HIDDEN_UNITS/GLOBAL_OUTPUTS/INPUTS constants;
  - `WORD_W` default.
- One natural sub-module, `bnn_word_serializer`: the shift register plus in-word index with load/shift/empty signals. The FSM and total counter stay in `bnn_param_loader`.

## Test plan

- **Full load:** `CHAIN_BITS`=16, `WORD_W`=8, words 0xA5, 0x3C with `in_valid` held high → `param_bit` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with `setup`=1 on exactly 16 cycles. `done` pulses once.
- **Host stall:** drop `in_valid` for 5 cycles between words → `setup`=0 during the gap, and the bit sequence is unchanged.
- **Partial last word:** `CHAIN_BITS`=12, `WORD_W`=8, words 0xFF, 0x0F → 12 setup-high cycles. Bits 12–15 are never driven. 2 words accepted.
- **Reset mid-pass:** `rst_n`=0 after 5 shifted bits → next cycle all outputs at reset values. A new `start` reloads from bit 0.
- **Verify:** with `BNN_LOADER_VERIFY_EN`, a model chain of depth 16, load 0xA5, 0x3C, then a verify pass with the same words → `verify_err`=0. Repeat verify with the second word 0x3D → `verify_err`=1, held after `done`.
- **Ignored start:** pulse `start` while `busy` → no restart, pass completes normally, `done` pulses once.
